// File: rtl/four_func_sequencer_pkg.sv
// Shared types for the fourFunc request sequencer: FSM state encoding and the
// function codes understood by the fourFunc evaluator.
package four_func_sequencer_pkg;

    localparam int unsigned FuncWidth = 2;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StIssue    = 3'd1,
        StWaitBusy = 3'd2,
        StWaitDone = 3'd3,
        StHold     = 3'd4
    } seq_state_e;

    typedef enum logic [FuncWidth-1:0] {
        FuncCode0 = 2'b00,
        FuncCode1 = 2'b01,
        FuncCode2 = 2'b10,
        FuncCode3 = 2'b11
    } four_func_e;

endpackage

// File: rtl/four_func_req_fifo.sv
// Request queue in front of the fourFunc issue FSM; power-of-two depth with
// wrapping pointers and an occupancy count, all cleared by synchronous reset.
module four_func_req_fifo #(
    parameter int unsigned Depth    = 4,
    parameter int unsigned PtrWidth = 2,
    parameter int unsigned Width    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [Width-1:0]    wdata,
    input  logic                pop,
    output logic [Width-1:0]    rdata,
    output logic                full,
    output logic                empty,
    output logic [PtrWidth:0]   count
);

    localparam logic [PtrWidth-1:0] PtrOne    = PtrWidth'(1);
    localparam logic [PtrWidth:0]   CountOne  = (PtrWidth + 1)'(1);
    localparam logic [PtrWidth:0]   CountFull = (PtrWidth + 1)'(Depth);

    logic [Width-1:0]    mem_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
    logic [PtrWidth:0]   count_q;
    logic                do_push, do_pop;

    assign full    = (count_q == CountFull);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    // Full refuses a push even when a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + PtrOne;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CountOne;
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CountOne;
            end
        end
    end

endmodule

// File: rtl/four_func_sequencer.sv
// Queues {func, x} requests, issues them one at a time to fourFunc with a start
// pulse, and hands each captured result downstream over valid/ready.
module four_func_sequencer
    import four_func_sequencer_pkg::*;
#(
    parameter int unsigned F_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_WIDTH  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FuncWidth-1:0] in_func,
    input  logic [F_WIDTH-1:0]   in_x,
    output logic                 eng_start,
    output logic [FuncWidth-1:0] eng_func,
    output logic [F_WIDTH-1:0]   eng_x,
    input  logic                 eng_busy,
    input  logic [1:0]           eng_ipart,
    input  logic [F_WIDTH-1:0]   eng_fpart,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [FuncWidth-1:0] out_func,
    output logic [1:0]           out_ipart,
    output logic [F_WIDTH-1:0]   out_fpart,
    output logic [PTR_WIDTH:0]   pending
);

    localparam int unsigned ReqWidth = FuncWidth + F_WIDTH;

    seq_state_e             state_q, state_d;
    logic                   full, empty, pop, capture;
    logic [ReqWidth-1:0]    head;
    logic [FuncWidth-1:0]   eng_func_q, out_func_q;
    logic [F_WIDTH-1:0]     eng_x_q, out_fpart_q;
    logic [1:0]             out_ipart_q;
    logic                   out_valid_q;

    four_func_req_fifo #(
        .Depth    (FIFO_DEPTH),
        .PtrWidth (PTR_WIDTH),
        .Width    (ReqWidth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata ({in_func, in_x}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    assign in_ready = !full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue:    state_d = StWaitBusy;
            StWaitBusy: if (eng_busy) state_d = StWaitDone;
            StWaitDone: if (!eng_busy) state_d = StHold;
            StHold: begin
                // Issue the next request straight from HOLD to skip an IDLE bubble.
                if (out_ready) begin
                    pop     = !empty;
                    state_d = empty ? StIdle : StIssue;
                end
            end
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        eng_start = (state_q == StIssue);
        capture   = (state_q == StWaitDone) && !eng_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eng_func_q  <= '0;
            eng_x_q     <= '0;
            out_valid_q <= 1'b0;
            out_func_q  <= '0;
            out_ipart_q <= '0;
            out_fpart_q <= '0;
        end else begin
            if (pop) begin
                {eng_func_q, eng_x_q} <= head;
            end
            if (capture) begin
                out_valid_q <= 1'b1;
                out_func_q  <= eng_func_q;
                out_ipart_q <= eng_ipart;
                out_fpart_q <= eng_fpart;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign eng_func  = eng_func_q;
    assign eng_x     = eng_x_q;
    assign out_valid = out_valid_q;
    assign out_func  = out_func_q;
    assign out_ipart = out_ipart_q;
    assign out_fpart = out_fpart_q;

endmodule
